// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector controller.
//   state_t      : controller FSM encoding (IDLE=0, RUN=1, DONE=2, 3 unused)
//   ST_*         : run status codes reported on status
//   len_width()  : width of a pattern-length field for a given MAX_LEN
package seq_det_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] ST_NONE   = 2'b00;
    localparam logic [1:0] ST_TARGET = 2'b01;
    localparam logic [1:0] ST_WINDOW = 2'b10;
    localparam logic [1:0] ST_ABORT  = 2'b11;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and masked pattern compare.
//   clk, reset      : clock, async active-low reset
//   clr             : clear history and fill (new job)
//   shift           : accept bit_in this cycle
//   bit_in          : serial data
//   pattern, len    : latched pattern and its length
//   overlap         : 1 = keep fill after a match
//   match           : combinational, high in the cycle whose shift completes a match
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    localparam int LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               shift,
    input  logic               bit_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               match
);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_nxt;

    // match looks at the post-shift history so the top can count and
    // pulse on the same edge that samples the bit.
    always_comb begin
        hist_nxt = {hist[MAX_LEN-2:0], bit_in};
        fill_nxt = (fill >= len) ? len : fill + LEN_W'(1);
        mask     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        match = shift && (fill_nxt == len) &&
                ((hist_nxt & mask) == (pattern & mask));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= hist_nxt;
            // Non-overlapping mode needs len fresh bits after each match.
            fill <= (match && !overlap) ? '0 : fill_nxt;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for a programmable serial pattern detector.
//   Job request (cfg_*) accepted over valid/ready in IDLE; bits on
//   bit_valid/bit_in are scanned in RUN; run ends on target count, window
//   expiry or abort, then DONE pulses for one cycle with a status code.
//   Outputs: cfg_ready, cfg_err, busy, detected, match_count, bit_count,
//   done, status, state_out.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    parameter  int WIN_W   = 16,
    localparam int LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic [WIN_W-1:0]   cfg_window,
    output logic               cfg_err,
    input  logic               abort,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               busy,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic [WIN_W-1:0]   bit_count,
    output logic               done,
    output logic [1:0]         status,
    output logic [1:0]         state_out
);

    state_t             state;
    logic [MAX_LEN-1:0] job_pattern;
    logic [LEN_W-1:0]   job_len;
    logic               job_overlap;
    logic [CNT_W-1:0]   job_target;
    logic [WIN_W-1:0]   job_window;

    logic               len_ok;
    logic               accept;
    logic               shift;
    logic               match;
    logic [CNT_W-1:0]   mc_new;
    logic [WIN_W-1:0]   bc_new;

    assign len_ok = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);
    assign accept = (state == S_IDLE) && cfg_valid && len_ok;
    // Abort wins over a coincident bit: the bit is dropped entirely.
    assign shift  = (state == S_RUN) && bit_valid && !abort;

    // Counters saturate instead of wrapping.
    assign mc_new = (&match_count) ? match_count : match_count + CNT_W'(1);
    assign bc_new = (&bit_count)   ? bit_count   : bit_count + WIN_W'(1);

    assign cfg_ready = (state == S_IDLE);
    assign busy      = (state == S_RUN);
    assign state_out = state;

    seq_match_core #(.MAX_LEN(MAX_LEN)) u_core (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept),
        .shift   (shift),
        .bit_in  (bit_in),
        .pattern (job_pattern),
        .len     (job_len),
        .overlap (job_overlap),
        .match   (match)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            job_pattern <= '0;
            job_len     <= '0;
            job_overlap <= 1'b0;
            job_target  <= '0;
            job_window  <= '0;
            match_count <= '0;
            bit_count   <= '0;
            status      <= ST_NONE;
            cfg_err     <= 1'b0;
            detected    <= 1'b0;
            done        <= 1'b0;
        end else begin
            cfg_err  <= 1'b0;
            detected <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        if (len_ok) begin
                            job_pattern <= cfg_pattern;
                            job_len     <= cfg_len;
                            job_overlap <= cfg_overlap;
                            job_target  <= cfg_target;
                            job_window  <= cfg_window;
                            match_count <= '0;
                            bit_count   <= '0;
                            status      <= ST_NONE;
                            state       <= S_RUN;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        status <= ST_ABORT;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else if (bit_valid) begin
                        bit_count <= bc_new;
                        if (match) begin
                            match_count <= mc_new;
                            detected    <= 1'b1;
                        end
                        // Target takes priority when both limits hit on one bit.
                        if (match && (job_target != '0) && (mc_new == job_target)) begin
                            status <= ST_TARGET;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else if ((job_window != '0) && (bc_new == job_window)) begin
                            status <= ST_WINDOW;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
